// File: rtl/stencil_window_3x3_if.sv
// Pixel-stream and window-read bundle for the 3x3 stencil window.
// The DUT attaches through the slave modport; the producer/consumer attach through master.
interface stencil_window_3x3_if #(
  parameter int ELEMENT_WIDTH = 32
);
  // Handshake: no backpressure. A pixel is accepted on every posedge where t=1.
  // tout is a one-cycle pulse after the accept that completed a valid window.
  // That window stays readable on i_rd_data until the next accept.
  logic                               t;
  logic [ELEMENT_WIDTH-1:0]           pix_data;
  logic [2:0][2:0]                    i_rd_en;
  logic [2:0][2:0][ELEMENT_WIDTH-1:0] i_rd_data;
  logic                               tout;
  logic                               frame_done;
  logic                               rd_err;
  logic                               dbg_win_valid;

  modport master (
    output t, pix_data, i_rd_en,
    input  i_rd_data, tout, frame_done, rd_err, dbg_win_valid
  );

  modport slave (
    input  t, pix_data, i_rd_en,
    output i_rd_data, tout, frame_done, rd_err, dbg_win_valid
  );
endinterface

// File: rtl/stencil_window_3x3.sv
// 3x3 sliding window over a raster pixel stream, built from two line buffers.
// The window shifts one column per accepted pixel and is read combinationally.
module stencil_window_3x3 #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int IMG_WIDTH     = 64,
  parameter int IMG_HEIGHT    = 64
) (
  input  logic                clk,
  input  logic                rst,
  stencil_window_3x3_if.slave bus
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  typedef logic [ELEMENT_WIDTH-1:0] pix_t;

  logic [2:0][2:0][ELEMENT_WIDTH-1:0] win_q, win_d;
  pix_t                               lb0_q [IMG_WIDTH];
  pix_t                               lb1_q [IMG_WIDTH];
  logic [COL_W-1:0]                   col_q, col_d;
  logic [ROW_W-1:0]                   row_q, row_d;
  logic                               tout_q, tout_d;
  logic                               frame_done_q, frame_done_d;
  logic                               rd_err_q, rd_err_d;
  logic                               win_valid_q, win_valid_d;

  pix_t lb0_rd;
  pix_t lb1_rd;
  logic last_col;
  logic last_row;
  logic fire;

  assign lb0_rd   = lb0_q[col_q];
  assign lb1_rd   = lb1_q[col_q];
  assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
  // The pixel being accepted completes a full 3x3 block only from (2,2) onward in each row.
  assign fire     = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_comb begin
    win_d        = win_q;
    col_d        = col_q;
    row_d        = row_q;
    tout_d       = 1'b0;
    frame_done_d = 1'b0;
    win_valid_d  = win_valid_q;
    rd_err_d     = rd_err_q | ((|bus.i_rd_en) & ~win_valid_q);
    if (bus.t) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2]  = lb0_rd;
      win_d[1][2]  = lb1_rd;
      win_d[2][2]  = bus.pix_data;
      col_d        = last_col ? '0 : col_q + COL_W'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end
      tout_d       = fire;
      frame_done_d = last_col && last_row;
      win_valid_d  = fire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      tout_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_err_q     <= 1'b0;
      win_valid_q  <= 1'b0;
    end else begin
      win_q        <= win_d;
      col_q        <= col_d;
      row_q        <= row_d;
      tout_q       <= tout_d;
      frame_done_q <= frame_done_d;
      rd_err_q     <= rd_err_d;
      win_valid_q  <= win_valid_d;
    end
  end

  // Line buffers are plain storage: never cleared, and a pixel in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && bus.t) begin
      lb0_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= bus.pix_data;
    end
  end

  assign bus.i_rd_data     = win_q;
  assign bus.tout          = tout_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.rd_err        = rd_err_q;
  assign bus.dbg_win_valid = win_valid_q;
endmodule
